layer_61_mac: RTL and testbench



---
 rtl/layer_61_pkg.sv | 38 +++
 rtl/layer_61_sat.sv | 34 +++
 rtl/layer_61_mac.sv | 138 +++++++++++++
 tb/tb_layer_61_mac.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_61_pkg.sv
// layer_61_pkg: shared widths, weights, bias and FSM state type for the
// layer_61 output reduction MAC. Regenerated by the network generator; the
// RTL reads weights only through weight() and B.
package layer_61_pkg;

  localparam int unsigned ACT_W  = 16;
  localparam int unsigned WGT_W  = 10;
  localparam int unsigned ACC_W  = 29;
  localparam int unsigned PROD_W = ACT_W + WGT_W;
  localparam int unsigned PRE_W  = 28;
  localparam int unsigned N_TAPS = 6;
  localparam int unsigned IDX_W  = 3;

  typedef logic signed [ACT_W-1:0] act_t;

  // Output bias
  localparam act_t B = 16'sh0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Per-tap weight lookup: +4, -2, +1, 0, -8, +3
  function automatic logic signed [WGT_W-1:0] weight(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    return 10'sh004;
      3'd1:    return 10'sh3FE;
      3'd2:    return 10'sh001;
      3'd3:    return 10'sh000;
      3'd4:    return 10'sh3F8;
      3'd5:    return 10'sh003;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/layer_61_sat.sv
// layer_61_sat: combinational 28->16 bit reduction of the pre-result.
// Macro LAYER_61_SAT_EN: defined -> clamp to [-32768, 32767];
// undefined -> two's-complement wrap (keep low 16 bits).
// Ports:
//   pre_i   : signed 28-bit shifted-and-biased sum
//   res_c_o : 16-bit reduced result (combinational)
module layer_61_sat
  import layer_61_pkg::*;
(
  input  logic signed [PRE_W-1:0] pre_i,
  output logic        [ACT_W-1:0] res_c_o
);

`ifdef LAYER_61_SAT_EN
  localparam logic signed [PRE_W-1:0] MAX_V = PRE_W'(32'sd32767);
  localparam logic signed [PRE_W-1:0] MIN_V = PRE_W'(-32'sd32768);

  // Clamp to the signed 16-bit range
  always_comb begin
    res_c_o = pre_i[ACT_W-1:0];
    if (pre_i > MAX_V) begin
      res_c_o = 16'h7FFF;
    end else if (pre_i < MIN_V) begin
      res_c_o = 16'h8000;
    end
  end
`else
  // Wrap: upper bits are intentionally discarded
  logic unused_hi;
  assign unused_hi = ^pre_i[PRE_W-1:ACT_W];
  assign res_c_o   = pre_i[ACT_W-1:0];
`endif

endmodule

// File: rtl/layer_61_mac.sv
// layer_61_mac: six-tap output reduction, out1 = (sum in_k*w_k) >>> SHIFT + B.
// One 16x10 multiplier is time-shared over six MAC cycles.
// Macro LAYER_61_SAT_EN selects saturating (defined) or wrapping output.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in1..in6            : signed activations, captured on accept
//   in_valid / in_ready : input handshake
//   out1                : signed result
//   out_valid/out_ready : output handshake
module layer_61_mac
  import layer_61_pkg::*;
#(
  parameter int unsigned SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACT_W-1:0] in1,
  input  logic [ACT_W-1:0] in2,
  input  logic [ACT_W-1:0] in3,
  input  logic [ACT_W-1:0] in4,
  input  logic [ACT_W-1:0] in5,
  input  logic [ACT_W-1:0] in6,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACT_W-1:0] out1,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e                    state_q, state_d;
  act_t [N_TAPS-1:0]         x_q, x_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [ACT_W-1:0]          out1_q, out1_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;

  act_t                      x_sel_c;
  logic signed [WGT_W-1:0]   w_sel_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [ACC_W-1:0]   sum_c;
  logic signed [PRE_W-1:0]   shift_c;
  logic signed [PRE_W-1:0]   pre_c;
  logic [ACT_W-1:0]          res_c;

  // Operand select for the current tap
  always_comb begin
    x_sel_c = '0;
    for (int i = 0; i < int'(N_TAPS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_sel_c = x_q[i];
      end
    end
  end

  assign w_sel_c = weight(idx_q);
  assign prod_c  = PROD_W'(x_sel_c) * PROD_W'(w_sel_c);
  assign sum_c   = acc_q + ACC_W'(prod_c);
  // Arithmetic shift floors toward -inf; |sum| fits well inside 28 bits
  assign shift_c = PRE_W'(sum_c >>> SHIFT);
  assign pre_c   = shift_c + PRE_W'(B);

  layer_61_sat u_sat (
    .pre_i   (pre_c),
    .res_c_o (res_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out1_d      = out1_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      ST_IDLE: begin
        // in_ready rises one edge after reset release and stays up in IDLE
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          x_d        = {in6, in5, in4, in3, in2, in1};
          acc_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = sum_c;
        idx_d = idx_q + IDX_W'(1);
        // Last tap: result taken from the combinational sum, not acc_q
        if (idx_q == IDX_W'(N_TAPS - 1)) begin
          out1_d      = res_c;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out1      = out1_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_layer_61_mac.sv
// tb_layer_61_mac: scoreboard bench for layer_61_mac. Drives and samples on
// the falling clock edge; expected results are queued when a vector is sent.
module tb_layer_61_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0, in5 = '0, in6 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out1;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sb[$];

  typedef int vec_t[6];

  always #5 clk = ~clk;

  layer_61_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .in5       (in5),
    .in6       (in6),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Reference model of the reduction
  function automatic logic [15:0] model(input vec_t v);
    int w[6];
    int s;
    int pre;
    w = '{4, -2, 1, 0, -8, 3};
    s = 0;
    for (int i = 0; i < 6; i++) s += v[i] * w[i];
    pre = (s >>> 2) + 16;
`ifdef LAYER_61_SAT_EN
    if (pre > 32767) return 16'h7FFF;
    if (pre < -32768) return 16'h8000;
`endif
    return pre[15:0];
  endfunction

  task automatic drive_vec(input vec_t v);
    in1 = 16'(v[0]); in2 = 16'(v[1]); in3 = 16'(v[2]);
    in4 = 16'(v[3]); in5 = 16'(v[4]); in6 = 16'(v[5]);
  endtask

  task automatic scramble_inputs();
    in1 = 16'($urandom); in2 = 16'($urandom); in3 = 16'($urandom);
    in4 = 16'($urandom); in5 = 16'($urandom); in6 = 16'($urandom);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 6; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
    return v;
  endfunction

  // Present one vector for a single accept edge, queue its expected result.
  // Entered and left on a falling edge; returns just after the accept edge.
  task automatic send(input vec_t v, input logic [15:0] exp);
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    drive_vec(v);
    in_valid = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Wait for out_valid after an accept, check latency and popped result
  task automatic recv(input string tag);
    int lat = 0;
    logic [15:0] exp;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 6) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles required 6", tag, lat);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_result: scoreboard empty, out1=%h", tag, out1);
    end else begin
      exp = sb.pop_front();
      if (out1 !== exp) begin
        n_fail++;
        $display("FAIL %s_result: out1=%h required %h", tag, out1, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out1=%h required 0 0 0000",
               in_ready, out_valid, out1);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_edge_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  // Directed vectors with hand-derived results, then random ones via the model
  task automatic test_vectors();
    vec_t        vecs[6];
    logic [15:0] exps[6];
    vecs[0] = '{100, 100, 100, 100, 100, 100};  exps[0] = 16'hFFDE;
    vecs[1] = '{1000, 0, 0, 0, 0, 0};           exps[1] = 16'h03F8;
    vecs[2] = '{0, 0, -1, 0, 0, 0};             exps[2] = 16'h000F;
    vecs[3] = '{0, 0, 0, 0, -32768, 0};
    vecs[4] = '{0, 0, 0, 0, 32767, 0};
    vecs[5] = '{-32768, 32767, -32768, 32767, 32767, -32768};
`ifdef LAYER_61_SAT_EN
    exps[3] = 16'h7FFF;
    exps[4] = 16'h8000;
`else
    exps[3] = 16'h0010;
    exps[4] = 16'h0012;
`endif
    exps[5] = model(vecs[5]);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      logic [15:0] e;
      if (i < 6) begin
        v = vecs[i];
        e = exps[i];
      end else begin
        v = rand_vec();
        e = model(v);
      end
      send(v, e);
      recv($sformatf("vec%0d", i));
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL vec%0d_handshake: out_valid=%b in_ready=%b required 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  // in_valid held high: accepts must be 8 cycles apart
  task automatic test_back_to_back();
    vec_t vs[3];
    int   acc_cyc[3];
    int   vi = 0;
    int   got = 0;
    logic reload = 1'b0;
    for (int i = 0; i < 3; i++) vs[i] = rand_vec();
    out_ready = 1'b1;
    drive_vec(vs[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      if (out_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_result: scoreboard empty, out1=%h", out1);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          if (out1 !== e) begin
            n_fail++;
            $display("FAIL b2b_result%0d: out1=%h required %h", got, out1, e);
          end
        end
        got++;
      end
      if (reload) begin
        reload = 1'b0;
        if (vi < 3) drive_vec(vs[vi]);
        else in_valid = 1'b0;
      end
      if (in_ready === 1'b1 && in_valid && vi < 3) begin
        sb.push_back(model(vs[vi]));
        acc_cyc[vi] = c;
        vi++;
        reload = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 3 || vi != 3) begin
      n_fail++;
      $display("FAIL b2b_count: outputs=%0d accepts=%0d required 3 3", got, vi);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 8) begin
          n_fail++;
          $display("FAIL b2b_interval%0d: got %0d cycles required 8",
                   i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t v;
    logic [15:0] e;
    int bad = 0;
    v = '{1000, 0, 0, 0, 0, 0};
    e = 16'h03F8;
    out_ready = 1'b0;
    send(v, e);
    recv("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      scramble_inputs();
      @(negedge clk);
      n_checks++;
      if (out1 !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: out1=%h out_valid=%b in_ready=%b required %h 1 0",
                 i, out1, out_valid, in_ready, e);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pulse: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_single_output: extra out_valid cycles=%0d queued=%0d required 0 0",
               bad, sb.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    vec_t v;
    int bad = 0;
    v = '{100, 100, 100, 100, 100, 100};
    out_ready = 1'b1;
    send(v, 16'hFFDE);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out1 !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: out1=%h out_valid=%b in_ready=%b required 0000 0 0",
               out1, out_valid, in_ready);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: in_ready=%b required 1", in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset_no_output: out_valid cycles=%0d required 0", bad);
    end
    send(v, 16'hFFDE);
    recv("post_reset");
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
